// File: rtl/axi_selftest_top.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : axi_selftest_top
// Brief    : AXI4 loopback self-test. Traffic master writes a burst into a
//            memory-backed slave, reads it back, and the slave checks it.
// Revision : 1.0  initial release
// ============================================================================

package axi_selftest_pkg;
    // Data pattern stored at (and expected from) byte address A.
    function automatic logic [31:0] f_pattern(input logic [7:0] i_addr);
        return {8'hA5, ~i_addr, 8'h5A, i_addr};
    endfunction
endpackage

// ----------------------------------------------------------------------------
// Traffic master: write burst, B response, read-back burst, advance base.
// ----------------------------------------------------------------------------
module axi_selftest_mst #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_WORDS  = 16,
    parameter int BURST_LEN  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic [ADDR_WIDTH-1:0]   o_awaddr,
    output logic [7:0]              o_awlen,
    output logic [2:0]              o_awsize,
    output logic [1:0]              o_awburst,
    output logic                    o_awvalid,
    input  logic                    i_awready,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [DATA_WIDTH/8-1:0] o_wstrb,
    output logic                    o_wlast,
    output logic                    o_wvalid,
    input  logic                    i_wready,
    input  logic [1:0]              i_bresp,
    input  logic                    i_bvalid,
    output logic                    o_bready,
    output logic [ADDR_WIDTH-1:0]   o_araddr,
    output logic [7:0]              o_arlen,
    output logic                    o_arvalid,
    input  logic                    i_arready,
    input  logic [DATA_WIDTH-1:0]   i_rdata,
    input  logic [1:0]              i_rresp,
    input  logic                    i_rlast,
    input  logic                    i_rvalid,
    output logic                    o_rready
);
    import axi_selftest_pkg::*;

    localparam int BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int BURST_BYTES = BURST_LEN * (DATA_WIDTH / 8);
    localparam int MEM_BYTES   = MEM_WORDS * (DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] C_BURST_BYTES = ADDR_WIDTH'(BURST_BYTES);
    localparam logic [ADDR_WIDTH-1:0] C_LAST_BASE   = ADDR_WIDTH'(MEM_BYTES - BURST_BYTES);
    localparam logic [BEAT_W-1:0]     C_LAST_BEAT   = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_ADDR = 3'd1,
        S_WR_DATA = 3'd2,
        S_WR_RESP = 3'd3,
        S_RD_ADDR = 3'd4,
        S_RD_DATA = 3'd5,
        S_NEXT    = 3'd6
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [BEAT_W-1:0]       r_beat;
    logic [BEAT_W-1:0]       w_beat_nxt;
    logic [ADDR_WIDTH-1:0]   r_base;
    logic [ADDR_WIDTH-1:0]   w_base_nxt;
    logic [15:0]             r_burst_cnt;
    logic [15:0]             w_cnt_nxt;
    logic [ADDR_WIDTH-1:0]   w_beat_addr;
    logic                    r_resp_err;
    logic [DATA_WIDTH-1:0]   r_rd_sig;

    assign w_beat_addr = r_base + ADDR_WIDTH'({r_beat, 2'b00});
    assign o_awaddr    = r_base;
    assign o_araddr    = r_base;
    assign o_awlen     = 8'(BURST_LEN - 1);
    assign o_arlen     = 8'(BURST_LEN - 1);
    assign o_awsize    = 3'($clog2(DATA_WIDTH / 8));
    assign o_awburst   = 2'b01;
    assign o_wstrb     = '1;
    assign o_wdata     = DATA_WIDTH'(f_pattern(w_beat_addr[7:0]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_beat      <= '0;
            r_base      <= '0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_beat      <= w_beat_nxt;
            r_base      <= w_base_nxt;
            r_burst_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat;
        w_base_nxt  = r_base;
        w_cnt_nxt   = r_burst_cnt;
        o_awvalid   = 1'b0;
        o_wvalid    = 1'b0;
        o_wlast     = 1'b0;
        o_bready    = 1'b0;
        o_arvalid   = 1'b0;
        o_rready    = 1'b0;
        case (r_state)
            S_IDLE: w_state_nxt = S_WR_ADDR;
            S_WR_ADDR: begin
                o_awvalid  = 1'b1;
                w_beat_nxt = '0;
                if (i_awready) w_state_nxt = S_WR_DATA;
            end
            S_WR_DATA: begin
                o_wvalid = 1'b1;
                o_wlast  = (r_beat == C_LAST_BEAT);
                if (i_wready) begin
                    if (r_beat == C_LAST_BEAT) begin
                        w_beat_nxt  = '0;
                        w_state_nxt = S_WR_RESP;
                    end else begin
                        w_beat_nxt = r_beat + 1'b1;
                    end
                end
            end
            S_WR_RESP: begin
                o_bready = 1'b1;
                if (i_bvalid) w_state_nxt = S_RD_ADDR;
            end
            S_RD_ADDR: begin
                o_arvalid = 1'b1;
                if (i_arready) w_state_nxt = S_RD_DATA;
            end
            S_RD_DATA: begin
                o_rready = 1'b1;
                if (i_rvalid && i_rlast) w_state_nxt = S_NEXT;
            end
            S_NEXT: begin
                w_base_nxt  = (r_base == C_LAST_BASE) ? '0 : r_base + C_BURST_BYTES;
                w_cnt_nxt   = r_burst_cnt + 16'd1;
                w_state_nxt = S_WR_ADDR;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Sticky response-error flag and running read-data signature for debug.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_resp_err <= 1'b0;
            r_rd_sig   <= '0;
        end else begin
            r_resp_err <= r_resp_err
                        | (o_bready & i_bvalid & (i_bresp != 2'b00))
                        | (o_rready & i_rvalid & (i_rresp != 2'b00));
            if (o_rready && i_rvalid) r_rd_sig <= r_rd_sig ^ i_rdata;
        end
    end
endmodule

// ----------------------------------------------------------------------------
// Memory-backed slave with read-data self-check (sticky rd_data_err).
// ----------------------------------------------------------------------------
module axi_selftest_slv #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_WORDS  = 16,
    parameter int BURST_LEN  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    input  logic [7:0]              i_awlen,
    input  logic [2:0]              i_awsize,
    input  logic [1:0]              i_awburst,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_wstrb,
    input  logic                    i_wlast,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    output logic [1:0]              o_bresp,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    input  logic [ADDR_WIDTH-1:0]   i_araddr,
    input  logic [7:0]              i_arlen,
    input  logic                    i_arvalid,
    output logic                    o_arready,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic [1:0]              o_rresp,
    output logic                    o_rlast,
    output logic                    o_rvalid,
    input  logic                    i_rready
);
    import axi_selftest_pkg::*;

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam logic [2:0] C_SIZE = 3'($clog2(DATA_WIDTH / 8));
    localparam logic [7:0] C_LEN  = 8'(BURST_LEN - 1);

    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];
    logic [MEM_WORDS-1:0]  r_mem_vld;
    logic                  r_awready;
    logic                  r_wready;
    logic                  r_bvalid;
    logic                  r_wbad;
    logic                  r_arready;
    logic                  r_rvalid;
    logic                  r_rlast;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [7:0]            r_rlen;
    logic [7:0]            r_rbeat;
    logic                  rd_data_err;
    logic                  w_wfire;
    logic                  w_rfire;
    logic                  w_aw_bad;
    logic                  w_rd_bad;
    logic [IDX_W-1:0]      w_widx;
    logic [IDX_W-1:0]      w_ridx;
    logic [DATA_WIDTH-1:0] w_rexp;

    assign w_wfire  = r_wready & i_wvalid;
    assign w_rfire  = r_rvalid & i_rready;
    // Upper address bits fall away here: the memory aliases every 64 bytes.
    assign w_widx   = r_waddr[IDX_W+1:2];
    assign w_ridx   = r_raddr[IDX_W+1:2];
    assign w_aw_bad = (i_awlen != C_LEN) || (i_awsize != C_SIZE) || (i_awburst != 2'b01);
    assign w_rexp   = DATA_WIDTH'(f_pattern(r_raddr[7:0]));
    assign w_rd_bad = !r_mem_vld[w_ridx] || (o_rdata != w_rexp);

    assign o_awready = r_awready;
    assign o_wready  = r_wready;
    assign o_bvalid  = r_bvalid;
    assign o_bresp   = (r_bvalid && r_wbad) ? 2'b10 : 2'b00;
    assign o_arready = r_arready;
    assign o_rvalid  = r_rvalid;
    assign o_rlast   = r_rlast;
    assign o_rresp   = 2'b00;
    assign o_rdata   = r_mem[w_ridx];

    always_ff @(posedge clk) begin
        if (w_wfire) r_mem[w_widx] <= i_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_wbad    <= 1'b0;
            r_waddr   <= '0;
            r_mem_vld <= '0;
        end else begin
            if (r_awready && i_awvalid) begin
                r_awready <= 1'b0;
                r_wready  <= 1'b1;
                r_waddr   <= i_awaddr;
                r_wbad    <= w_aw_bad;
            end else if (!r_wready && !r_bvalid && !r_awready) begin
                r_awready <= 1'b1;
            end
            if (w_wfire) begin
                r_mem_vld[w_widx] <= 1'b1;
                r_waddr           <= r_waddr + ADDR_WIDTH'(DATA_WIDTH / 8);
                if (i_wstrb != '1) r_wbad <= 1'b1;
                if (i_wlast) begin
                    r_wready <= 1'b0;
                    r_bvalid <= 1'b1;
                end
            end
            if (r_bvalid && i_bready) r_bvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_arready   <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rlast     <= 1'b0;
            r_raddr     <= '0;
            r_rlen      <= '0;
            r_rbeat     <= '0;
            rd_data_err <= 1'b0;
        end else begin
            if (r_arready && i_arvalid) begin
                r_arready <= 1'b0;
                r_rvalid  <= 1'b1;
                r_raddr   <= i_araddr;
                r_rlen    <= i_arlen;
                r_rbeat   <= '0;
                r_rlast   <= (i_arlen == 8'd0);
            end else if (!r_arready && !r_rvalid) begin
                r_arready <= 1'b1;
            end
            if (w_rfire) begin
                r_raddr <= r_raddr + ADDR_WIDTH'(DATA_WIDTH / 8);
                r_rbeat <= r_rbeat + 8'd1;
                r_rlast <= ((r_rbeat + 8'd1) == r_rlen);
                if (r_rlast) begin
                    r_rvalid <= 1'b0;
                    r_rlast  <= 1'b0;
                end
            end
            rd_data_err <= rd_data_err | (w_rfire & w_rd_bad);
        end
    end
endmodule

// ----------------------------------------------------------------------------
// Top: one master, one slave, one AXI4 link. rst_n is active-high.
// ----------------------------------------------------------------------------
module axi_selftest_top #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_WORDS  = 16,
    parameter int BURST_LEN  = 4
) (
    input  logic clk,
    input  logic rst_n
);
    logic [ADDR_WIDTH-1:0]   w_awaddr;
    logic [7:0]              w_awlen;
    logic [2:0]              w_awsize;
    logic [1:0]              w_awburst;
    logic                    w_awvalid;
    logic                    w_awready;
    logic [DATA_WIDTH-1:0]   w_wdata;
    logic [DATA_WIDTH/8-1:0] w_wstrb;
    logic                    w_wlast;
    logic                    w_wvalid;
    logic                    w_wready;
    logic [1:0]              w_bresp;
    logic                    w_bvalid;
    logic                    w_bready;
    logic [ADDR_WIDTH-1:0]   w_araddr;
    logic [7:0]              w_arlen;
    logic                    w_arvalid;
    logic                    w_arready;
    logic [DATA_WIDTH-1:0]   w_rdata;
    logic [1:0]              w_rresp;
    logic                    w_rlast;
    logic                    w_rvalid;
    logic                    w_rready;

    axi_selftest_mst #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_WORDS  (MEM_WORDS),
        .BURST_LEN  (BURST_LEN)
    ) u_axi_mst (
        .clk       (clk),
        .rst       (rst_n),
        .o_awaddr  (w_awaddr),
        .o_awlen   (w_awlen),
        .o_awsize  (w_awsize),
        .o_awburst (w_awburst),
        .o_awvalid (w_awvalid),
        .i_awready (w_awready),
        .o_wdata   (w_wdata),
        .o_wstrb   (w_wstrb),
        .o_wlast   (w_wlast),
        .o_wvalid  (w_wvalid),
        .i_wready  (w_wready),
        .i_bresp   (w_bresp),
        .i_bvalid  (w_bvalid),
        .o_bready  (w_bready),
        .o_araddr  (w_araddr),
        .o_arlen   (w_arlen),
        .o_arvalid (w_arvalid),
        .i_arready (w_arready),
        .i_rdata   (w_rdata),
        .i_rresp   (w_rresp),
        .i_rlast   (w_rlast),
        .i_rvalid  (w_rvalid),
        .o_rready  (w_rready)
    );

    axi_selftest_slv #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_WORDS  (MEM_WORDS),
        .BURST_LEN  (BURST_LEN)
    ) u_axi_slv (
        .clk       (clk),
        .rst       (rst_n),
        .i_awaddr  (w_awaddr),
        .i_awlen   (w_awlen),
        .i_awsize  (w_awsize),
        .i_awburst (w_awburst),
        .i_awvalid (w_awvalid),
        .o_awready (w_awready),
        .i_wdata   (w_wdata),
        .i_wstrb   (w_wstrb),
        .i_wlast   (w_wlast),
        .i_wvalid  (w_wvalid),
        .o_wready  (w_wready),
        .o_bresp   (w_bresp),
        .o_bvalid  (w_bvalid),
        .i_bready  (w_bready),
        .i_araddr  (w_araddr),
        .i_arlen   (w_arlen),
        .i_arvalid (w_arvalid),
        .o_arready (w_arready),
        .o_rdata   (w_rdata),
        .o_rresp   (w_rresp),
        .o_rlast   (w_rlast),
        .o_rvalid  (w_rvalid),
        .i_rready  (w_rready)
    );
endmodule
`default_nettype wire

// File: tb/tb_axi_selftest_top.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_axi_selftest_top
// Brief    : Scoreboard bench for the AXI4 loopback self-test subsystem.
// Revision : 1.0  initial release
// ============================================================================
module tb_axi_selftest_top;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    axi_selftest_top #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (8),
        .MEM_WORDS  (16),
        .BURST_LEN  (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n)
    );

    typedef struct packed { logic [7:0] addr; logic [15:0] cnt; } aw_t;
    typedef struct packed { logic [31:0] data; logic last; } w_t;
    typedef struct packed { logic [31:0] data; logic last; logic [1:0] resp; logic err; } r_t;

    aw_t q_aw[$];
    w_t  q_w[$];
    r_t  q_r[$];
    aw_t ea;
    w_t  ew;
    r_t  er;
    int  n_vec  = 0;
    int  n_err  = 0;
    bit  mon_en = 1'b0;
    bit  found;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pat(input logic [7:0] a);
        return {8'hA5, ~a, 8'h5A, a};
    endfunction

    // Burst k of a run: base wraps every 4 bursts; bad_beat carries forced zero data.
    task automatic push_burst(input int k, input int bad_beat, input bit err_before);
        logic [7:0]  base;
        logic [31:0] d;
        base = 8'((k * 16) % 64);
        q_aw.push_back('{addr: base, cnt: 16'(k)});
        for (int i = 0; i < 4; i++) begin
            d = (i == bad_beat) ? 32'h0 : pat(base + 8'(4 * i));
            q_w.push_back('{data: d, last: (i == 3)});
            q_r.push_back('{data: d, last: (i == 3), resp: 2'b00,
                            err: err_before || (bad_beat >= 0 && i > bad_beat)});
        end
    endtask

    task automatic clear_q();
        q_aw.delete();
        q_w.delete();
        q_r.delete();
    endtask

    task automatic drain(input int max_cyc);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(posedge clk);
            if (q_aw.size() == 0 && q_w.size() == 0 && q_r.size() == 0) done = 1'b1;
        end
        #1 mon_en = 1'b0;
        check("drain", 64'(done), 64'd1);
    endtask

    task automatic check_idle_bus(input string name);
        check(name, 64'({dut.w_awvalid, dut.w_wvalid, dut.w_bvalid, dut.w_arvalid, dut.w_rvalid}), 64'd0);
    endtask

    // Monitor: samples at the falling edge, i.e. the values that the next rising edge transfers.
    always @(negedge clk) begin
        if (mon_en) begin
            if (dut.w_awvalid && dut.w_awready) begin
                if (q_aw.size() == 0) check("aw_extra", 64'd1, 64'd0);
                else begin
                    ea = q_aw.pop_front();
                    check("awaddr", 64'(dut.w_awaddr), 64'(ea.addr));
                    check("awlen", 64'(dut.w_awlen), 64'd3);
                    check("burst_cnt", 64'(dut.u_axi_mst.r_burst_cnt), 64'(ea.cnt));
                end
            end
            if (dut.w_wvalid && dut.w_wready) begin
                if (q_w.size() == 0) check("w_extra", 64'd1, 64'd0);
                else begin
                    ew = q_w.pop_front();
                    check("wdata", 64'(dut.w_wdata), 64'(ew.data));
                    check("wlast", 64'(dut.w_wlast), 64'(ew.last));
                    check("wstrb", 64'(dut.w_wstrb), 64'hF);
                end
            end
            if (dut.w_bvalid && dut.w_bready) check("bresp", 64'(dut.w_bresp), 64'd0);
            if (dut.w_rvalid && dut.w_rready) begin
                if (q_r.size() == 0) check("r_extra", 64'd1, 64'd0);
                else begin
                    er = q_r.pop_front();
                    check("rdata", 64'(dut.w_rdata), 64'(er.data));
                    check("rlast", 64'(dut.w_rlast), 64'(er.last));
                    check("rresp", 64'(dut.w_rresp), 64'(er.resp));
                    check("rd_data_err", 64'(dut.u_axi_slv.rd_data_err), 64'(er.err));
                end
            end
        end
    end

    logic [31:0] hc [4];

    initial begin
        hc = '{32'hA5FF5A00, 32'hA5FB5A04, 32'hA5F75A08, 32'hA5F35A0C};

        // Reset state
        @(negedge clk);
        check_idle_bus("rst_valids");
        check("rst_readies", 64'({dut.w_awready, dut.w_wready, dut.w_arready, dut.w_bready, dut.w_rready}), 64'd0);
        check("rst_lasts", 64'({dut.w_wlast, dut.w_rlast}), 64'd0);
        check("rst_resps", 64'({dut.w_bresp, dut.w_rresp}), 64'd0);
        check("rst_err", 64'(dut.u_axi_slv.rd_data_err), 64'd0);
        check("rst_burst_cnt", 64'(dut.u_axi_mst.r_burst_cnt), 64'd0);
        check("rst_base", 64'(dut.u_axi_mst.r_base), 64'd0);

        // Free run: first burst hand-coded, later bursts from the pattern formula
        q_aw.push_back('{addr: 8'h00, cnt: 16'd0});
        for (int i = 0; i < 4; i++) begin
            q_w.push_back('{data: hc[i], last: (i == 3)});
            q_r.push_back('{data: hc[i], last: (i == 3), resp: 2'b00, err: 1'b0});
        end
        for (int k = 1; k < 100; k++) push_burst(k, -1, 1'b0);
        mon_en = 1'b1;
        rst_n  = 1'b0;
        repeat (1000) @(posedge clk);
        #1 mon_en = 1'b0;
        check("burst_cnt_ge_60", 64'(dut.u_axi_mst.r_burst_cnt >= 16'd60), 64'd1);
        check("err_free_run", 64'(dut.u_axi_slv.rd_data_err), 64'd0);
        clear_q();

        // Reset in the middle of a write data phase
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (dut.w_wvalid && dut.w_wready && dut.u_axi_mst.r_beat == 2'd1) found = 1'b1;
        end
        check("wait_mid_wdata", 64'(found), 64'd1);
        rst_n = 1'b1;
        #1 check_idle_bus("midrst_valids_now");
        repeat (2) begin
            @(negedge clk);
            check_idle_bus("midrst_valids");
            check("midrst_err", 64'(dut.u_axi_slv.rd_data_err), 64'd0);
        end
        for (int k = 0; k < 6; k++) push_burst(k, -1, 1'b0);
        mon_en = 1'b1;
        rst_n  = 1'b0;
        drain(200);
        check("err_after_midrst", 64'(dut.u_axi_slv.rd_data_err), 64'd0);

        // Corrupt word 1 of the first burst on its way into memory
        clear_q();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        push_burst(0, 1, 1'b0);
        for (int k = 1; k < 5; k++) push_burst(k, -1, 1'b1);
        mon_en = 1'b1;
        rst_n  = 1'b0;
        found  = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (dut.w_wvalid && dut.w_wready && dut.u_axi_mst.r_beat == 2'd0) found = 1'b1;
        end
        check("wait_first_wbeat", 64'(found), 64'd1);
        if (found) begin
            @(posedge clk);
            #1 force dut.w_wdata = 32'h0;
            @(posedge clk);
            #1 release dut.w_wdata;
        end
        drain(200);
        repeat (20) @(posedge clk);
        check("err_sticky", 64'(dut.u_axi_slv.rd_data_err), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/axi_selftest_top.md
Name: axi_selftest_top

Overview:
- Self-contained AXI4 loopback subsystem: internal traffic-generating master `u_axi_mst` drives a memory-backed slave `u_axi_slv` over one AXI4 link.
- Only clock and reset are external. The system runs indefinitely after reset: write burst, read-back of the same burst, next burst.
- The slave self-checks returned read data and raises a sticky error flag. Benches probe that flag hierarchically as `u_axi_slv.rd_data_err`.

Parameters:
- DATA_WIDTH, 32, AXI data width (full-word strobes only).
- ADDR_WIDTH, 8, AXI byte-address width.
- MEM_WORDS, 16, slave memory depth in words.
- BURST_LEN, 4, beats per burst (AWLEN/ARLEN = BURST_LEN-1).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-high reset: asserted while rst_n=1. Port name retained per codebase.

Behaviour:
- One clock. Reset is asynchronous and active-high. No external outputs; observability is via internal signals at fixed hierarchical names.
- Internal link signals:
  - AW: AWADDR, AWLEN, AWSIZE=2, AWBURST=INCR, AWVALID, AWREADY.
  - W: WDATA, WSTRB=4'hF, WLAST, WVALID, WREADY.
  - B: BRESP, BVALID, BREADY.
  - AR: ARADDR, ARLEN, ARVALID, ARREADY.
  - R: RDATA, RRESP, RLAST, RVALID, RREADY.
  - A transfer occurs when VALID & READY; VALID never drops before acceptance.
- Data pattern for byte address A: P(A) = {8'hA5, ~A[7:0], 8'h5A, A[7:0]}.
- Master FSM (`u_axi_mst`), states IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, NEXT:
  - IDLE: first cycle after reset release, go to WR_ADDR.
  - WR_ADDR: AWVALID=1, AWADDR=base. On accept go to WR_DATA.
  - WR_DATA: beats i=0..3 carry WDATA=P(base+4i); WLAST on i=3. After the last beat is accepted go to WR_RESP.
  - WR_RESP: BREADY=1. On B handshake go to RD_ADDR.
  - RD_ADDR: ARVALID=1, ARADDR=base. On accept go to RD_DATA.
  - RD_DATA: RREADY=1. After the RLAST beat go to NEXT.
  - NEXT: base += 16 bytes, wrapping 0x30 -> 0x00. Increment 16-bit burst_cnt (wraps). Go to WR_ADDR.
- Slave (`u_axi_slv`):
  - Memory: MEM_WORDS x DATA_WIDTH plus one valid bit per word. Word index = addr[5:2]; upper address bits are ignored.
  - Write path: AWREADY=1 when no write burst is active. Latch address, then WREADY=1 for the data phase. Each beat writes the word, sets its valid bit and advances the index by 1, wrapping mod 16.
  - Write response: the cycle after the WLAST beat, BVALID=1 with BRESP=OKAY, held until BREADY.
  - Read path: ARREADY=1 when no read burst is active. Starting the cycle after AR accept, RVALID=1 with RDATA=mem[idx], RRESP=OKAY. RLAST on beat BURST_LEN-1. Index advances on each handshake.
  - A stall (RREADY=0) holds RDATA, RLAST and RVALID stable.
  - Error check: on each R handshake, if the word's valid bit is 0 or RDATA != P(beat byte address), set rd_data_err=1.
  - rd_data_err is sticky; only reset clears it.
- Reset values:
  - All VALID/READY signals 0, RLAST/WLAST 0, BRESP/RRESP 0.
  - base=0x00, burst_cnt=0, master state IDLE.
  - All memory valid bits 0, rd_data_err 0. Memory contents are don't-care.
- Reset mid-burst: all channels abort immediately. After release, traffic restarts at base 0x00 with valid bits cleared. No error may be raised by the aborted burst.
- Simultaneous read and write channel activity is legal in the slave. The master serialises, so write and read never overlap in normal operation.
- Throughput: one burst pair completes in at most 16 cycles with no stalls.

Test Plan:
- Reset held 1 cycle, then 1000 cycles free-run -> rd_data_err stays 0 throughout; burst_cnt >= 60 at end.
- After reset release -> first AW handshake has AWADDR=0x00, AWLEN=3. First W beat is 0xA5FF5A00; fourth beat is 0xA5F35A0C with WLAST=1.
- First read burst -> RDATA sequence 0xA5FF5A00, 0xA5FB5A04, 0xA5F75A08, 0xA5F35A0C; RLAST only on the 4th beat; RRESP=0.
- After the 4th burst (base 0x30) -> next AWADDR is 0x00 (wrap); burst_cnt=4 at that point.
- Force-corrupt one memory word before its read-back (e.g. mem[1]=0) -> rd_data_err rises on the 2nd R beat of that burst and stays 1.
- Assert rst_n=1 mid-WR_DATA for 2 cycles -> all VALIDs 0 within the reset; after release the first AWADDR is 0x00 and rd_data_err remains 0.
